// File: rtl/tx_pkg.sv
// Shared types and sizing for the transmit path (cipher core -> tx_sr -> downstream).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tx_pkg;

   // SEND covers both "block held, first word waiting" and "words streaming out".
   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

   // Shared with tx_sr and the cipher/tx top level.
   localparam int TX_NUM_WORDS = 4;
   localparam int TX_WORD_BITS = 32;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and a programmable wrap value.
// Latency: count_out updates one cycle after count_enable/clear; rollover_flag is combinational.
// Backpressure: none; counts only when count_enable is high.
//
// Ports:
//   clk, n_rst     clock, async active-low reset
//   clear          synchronous return to zero (wins over count_enable)
//   count_enable   advance by one this cycle
//   rollover_val   last value before wrapping back to zero
//   count_out      current count
//   rollover_flag  count_out == rollover_val
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q;
   logic [NUM_CNT_BITS-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         // Wrap is an explicit compare, never a natural binary overflow.
         if (count_q == rollover_val) begin
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out     = count_q;
   assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/tx_ctrl.sv
// Sequences tx_sr: loads a 128-bit block on block handshake, shifts out one 32-bit word per word handshake.
// Latency: first word valid the cycle after the load; NUM_WORDS cycles per block at full rate, no gap back-to-back.
// Backpressure: word_ready low holds word_valid and the word counter; block_ready is low while a block is in flight.
//
// Ports:
//   clk, n_rst          clock, async active-low reset
//   clear               synchronous flush of the current block (highest priority)
//   block_valid/ready   block handshake with the cipher core
//   load_enable         tx_sr parallel load strobe
//   shift_enable        tx_sr advance-one-word strobe
//   word_valid/ready    word handshake with downstream; word_last marks word NUM_WORDS-1
//   busy                a block is held or being sent
//   block_done          one-cycle pulse the cycle after the last word is accepted
module tx_ctrl
   import tx_pkg::*;
#(
   parameter int NUM_WORDS = TX_NUM_WORDS,
   parameter int CNT_BITS  = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic block_valid,
   output logic block_ready,
   output logic load_enable,
   output logic shift_enable,
   output logic word_valid,
   input  logic word_ready,
   output logic word_last,
   output logic busy,
   output logic block_done
);

   tx_state_t           state_q;
   tx_state_t           state_d;
   logic                block_done_q;
   logic                block_done_d;
   logic [CNT_BITS-1:0] word_cnt;
   logic                cnt_at_last;
   logic                cnt_clr;
   logic                send;
   logic                wrd_acc;
   logic                last_acc;
   logic                blk_acc;

   assign send = (state_q == SEND);

   // clear gates every handshake-facing output in the cycle it is asserted.
   assign word_valid = send & ~clear;
   assign word_last  = word_valid & cnt_at_last;
   assign wrd_acc    = word_valid & word_ready;
   assign last_acc   = wrd_acc & word_last;

   // Accepting a new block is allowed while idle, or in the very cycle the
   // last word leaves so consecutive blocks stream without a bubble.
   assign block_ready = ~clear & (~send | last_acc);
   assign blk_acc     = block_valid & block_ready;

   // Load wins: on a back-to-back cycle the new block overwrites tx_sr instead of shifting.
   assign load_enable  = blk_acc;
   assign shift_enable = wrd_acc & ~word_last & ~load_enable;

   assign busy       = send;
   assign block_done = block_done_q;

   // Counter returns to zero at end of block or flush; a load from IDLE
   // always finds it already at zero.
   assign cnt_clr = clear | last_acc;

   flex_counter #(
      .NUM_CNT_BITS (CNT_BITS)
   ) u_word_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (cnt_clr),
      .count_enable  (shift_enable),
      .rollover_val  (CNT_BITS'(NUM_WORDS - 1)),
      .count_out     (word_cnt),
      .rollover_flag (cnt_at_last)
   );

   always_comb begin
      state_d      = state_q;
      block_done_d = last_acc;
      if (clear) begin
         state_d      = IDLE;
         block_done_d = 1'b0;
      end else if (blk_acc) begin
         state_d = SEND;
      end else if (last_acc) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         block_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         block_done_q <= block_done_d;
      end
   end

endmodule

// File: tb/tb_tx_ctrl.sv
// Self-checking bench for tx_ctrl: directed scenarios plus randomized traffic against a word-count model.
// Latency: n/a.
// Backpressure: driven randomly on word_ready.
module tb_tx_ctrl;

   localparam int NW = 4;

   logic clk;
   logic n_rst;
   logic clear;
   logic block_valid;
   logic block_ready;
   logic load_enable;
   logic shift_enable;
   logic word_valid;
   logic word_ready;
   logic word_last;
   logic busy;
   logic block_done;

   logic [127:0] blk_din;
   logic [127:0] sr;
   logic [31:0]  tx_word;

   int n_vec = 0;
   int n_err = 0;

   // Model: number of words of the current block still owed downstream.
   int           m_held;
   logic         m_done;
   logic [127:0] m_blk;

   tx_ctrl #(
      .NUM_WORDS (NW),
      .CNT_BITS  (2)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .block_valid  (block_valid),
      .block_ready  (block_ready),
      .load_enable  (load_enable),
      .shift_enable (shift_enable),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .word_last    (word_last),
      .busy         (busy),
      .block_done   (block_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural tx_sr: most significant word is presented first.
   always @(posedge clk) begin
      if (load_enable)       sr <= blk_din;
      else if (shift_enable) sr <= {sr[95:0], 32'h0};
   end
   assign tx_word = sr[127:96];

   function automatic logic [6:0] obs();
      return {block_ready, load_enable, shift_enable, word_valid, word_last, busy, block_done};
   endfunction

   // Expected outputs from the remaining-word count and current inputs.
   function automatic logic [6:0] model_exp();
      logic vld, last, rdy, acc, ld, sh;
      vld  = (m_held > 0) && !clear;
      last = (m_held == 1) && !clear;
      acc  = vld && word_ready;
      rdy  = !clear && ((m_held == 0) || ((m_held == 1) && word_ready));
      ld   = rdy && block_valid;
      sh   = acc && (m_held > 1);
      return {rdy, ld, sh, vld, last, (m_held > 0), m_done};
   endfunction

   always @(posedge clk or negedge n_rst) begin : model_upd
      logic [6:0] e;
      if (!n_rst) begin
         m_held = 0;
         m_done = 1'b0;
      end else begin
         e      = model_exp();
         m_done = e[3] && word_ready && (m_held == 1);
         if (e[5]) begin
            m_held = NW;
            m_blk  = blk_din;
         end else if (clear) begin
            m_held = 0;
         end else if (e[3] && word_ready) begin
            m_held = m_held - 1;
         end
      end
   end

   // Advance to just after the next rising edge, drive inputs, then wait for the sampling edge.
   task automatic step(input logic bv, input logic wr, input logic clr, input logic [127:0] din);
      @(posedge clk);
      #1;
      block_valid = bv;
      word_ready  = wr;
      clear       = clr;
      blk_din     = din;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [6:0] o;
      n_rst = 1'b0; clear = 1'b0; block_valid = 1'b0; word_ready = 1'b0; blk_din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      o = obs();
      n_vec++;
      if (o !== 7'b1000000) begin
         n_err++;
         $display("FAIL reset_idle: got %b want %b", o, 7'b1000000);
      end
      @(posedge clk);
      #1 n_rst = 1'b1;
   endtask

   task automatic test_single_block();
      logic [127:0] a;
      logic [6:0]   o;
      logic [6:0]   ex [6];
      a  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      ex = '{7'b1100000, 7'b0011010, 7'b0011010, 7'b0011010, 7'b1001110, 7'b1000001};
      for (int c = 0; c < 6; c++) begin
         step((c == 0), 1'b1, 1'b0, a);
         o = obs();
         n_vec++;
         if (o !== ex[c]) begin
            n_err++;
            $display("FAIL single_c%0d: got %b want %b", c, o, ex[c]);
         end
         if (c >= 1 && c <= 4) begin
            n_vec++;
            if (tx_word !== a[127-32*(c-1) -: 32]) begin
               n_err++;
               $display("FAIL single_word%0d: got %h want %h", c - 1, tx_word, a[127-32*(c-1) -: 32]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] a;
      logic [6:0]   o;
      logic [6:0]   ex [9];
      int           widx [9];
      logic         wr [9];
      a    = {$urandom, $urandom, $urandom, $urandom};
      ex   = '{7'b1100000, 7'b0001010, 7'b0001010, 7'b0001010, 7'b0011010,
               7'b0011010, 7'b0011010, 7'b1001110, 7'b1000001};
      widx = '{-1, 0, 0, 0, 0, 1, 2, 3, -1};
      wr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 9; c++) begin
         step((c == 0), wr[c], 1'b0, a);
         o = obs();
         n_vec++;
         if (o !== ex[c]) begin
            n_err++;
            $display("FAIL backpressure_c%0d: got %b want %b", c, o, ex[c]);
         end
         if (widx[c] >= 0) begin
            n_vec++;
            if (tx_word !== a[127-32*widx[c] -: 32]) begin
               n_err++;
               $display("FAIL backpressure_word_c%0d: got %h want %h", c, tx_word, a[127-32*widx[c] -: 32]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] a, b, want_blk;
      logic [6:0]   o;
      logic [6:0]   ex [10];
      int           widx [10];
      a    = {$urandom, $urandom, $urandom, $urandom};
      b    = {$urandom, $urandom, $urandom, $urandom};
      ex   = '{7'b1100000, 7'b0011010, 7'b0011010, 7'b0011010, 7'b1101110,
               7'b0011011, 7'b0011010, 7'b0011010, 7'b1001110, 7'b1000001};
      widx = '{-1, 0, 1, 2, 3, 0, 1, 2, 3, -1};
      for (int c = 0; c < 10; c++) begin
         step((c <= 4), 1'b1, 1'b0, (c < 4) ? a : b);
         o = obs();
         n_vec++;
         if (o !== ex[c]) begin
            n_err++;
            $display("FAIL b2b_c%0d: got %b want %b", c, o, ex[c]);
         end
         if (widx[c] >= 0) begin
            want_blk = (c < 5) ? a : b;
            n_vec++;
            if (tx_word !== want_blk[127-32*widx[c] -: 32]) begin
               n_err++;
               $display("FAIL b2b_word_c%0d: got %h want %h", c, tx_word, want_blk[127-32*widx[c] -: 32]);
            end
         end
      end
   endtask

   task automatic test_clear();
      logic [127:0] a;
      logic [6:0]   o;
      logic [6:0]   ex [6];
      a  = {$urandom, $urandom, $urandom, $urandom};
      ex = '{7'b1100000, 7'b0011010, 7'b0011010, 7'b0000010, 7'b1000000, 7'b1000000};
      for (int c = 0; c < 6; c++) begin
         // Block offered during clear must not be taken.
         step((c == 0) || (c == 3), 1'b1, (c == 3), a);
         o = obs();
         n_vec++;
         if (o !== ex[c]) begin
            n_err++;
            $display("FAIL clear_c%0d: got %b want %b", c, o, ex[c]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [127:0] a, b;
      logic [6:0]   o;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      step(1'b1, 1'b1, 1'b0, a);
      step(1'b0, 1'b1, 1'b0, a);
      step(1'b0, 1'b1, 1'b0, a);
      @(posedge clk);
      #1;
      word_ready = 1'b1;
      #2 n_rst = 1'b0;
      #1;
      o = obs();
      n_vec++;
      if (o !== 7'b1000000) begin
         n_err++;
         $display("FAIL async_reset_mid: got %b want %b", o, 7'b1000000);
      end
      @(posedge clk);
      #1 n_rst = 1'b1;
      step(1'b1, 1'b1, 1'b0, b);
      o = obs();
      n_vec++;
      if (o !== 7'b1100000) begin
         n_err++;
         $display("FAIL async_reload: got %b want %b", o, 7'b1100000);
      end
      step(1'b0, 1'b1, 1'b0, b);
      o = obs();
      n_vec++;
      if (o !== 7'b0011010 || tx_word !== b[127:96]) begin
         n_err++;
         $display("FAIL async_first_word: got %b/%h want %b/%h", o, tx_word, 7'b0011010, b[127:96]);
      end
   endtask

   task automatic test_random();
      logic [6:0] o, e;
      int         idx;
      logic [31:0] want;
      for (int c = 0; c < 3000; c++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
              {$urandom, $urandom, $urandom, $urandom});
         o = obs();
         e = model_exp();
         n_vec++;
         if (o !== e) begin
            n_err++;
            $display("FAIL random_ctl_c%0d: got %b want %b", c, o, e);
         end
         if (e[3] && word_ready) begin
            idx  = NW - m_held;
            want = m_blk[127-32*idx -: 32];
            n_vec++;
            if (tx_word !== want) begin
               n_err++;
               $display("FAIL random_word_c%0d: got %h want %h", c, tx_word, want);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
